// File: rtl/cpu_cu_pkg.sv
// cpu_cu_pkg -- shared definitions for the cpu_cu control unit.
//
// Contents:
//   state_e        FSM state encoding (RST, FETCH, DECODE, ALU, LDI, LD, ST, JMP, BR, HALT)
//   CLS_*          instruction class codes held in IR[11:9]
//   COND_*         branch condition codes held in IR[8:6]
//   *_MSB/*_LSB    instruction field positions
//   strobes_t      bundle of the per-state control strobes
//   state_strobes  Moore decode of the strobes for a given state
package cpu_cu_pkg;

    typedef enum logic [3:0] {
        ST_RST,
        ST_FETCH,
        ST_DECODE,
        ST_ALU,
        ST_LDI,
        ST_LD,
        ST_ST,
        ST_JMP,
        ST_BR,
        ST_HALT
    } state_e;

    localparam logic [2:0] CLS_ALU  = 3'b000;
    localparam logic [2:0] CLS_LDI  = 3'b001;
    localparam logic [2:0] CLS_LD   = 3'b010;
    localparam logic [2:0] CLS_ST   = 3'b011;
    localparam logic [2:0] CLS_JMP  = 3'b100;
    localparam logic [2:0] CLS_BR   = 3'b101;
    localparam logic [2:0] CLS_ILL  = 3'b110;
    localparam logic [2:0] CLS_HALT = 3'b111;

    localparam logic [2:0] COND_ALWAYS = 3'b000;
    localparam logic [2:0] COND_C      = 3'b001;
    localparam logic [2:0] COND_N      = 3'b010;
    localparam logic [2:0] COND_Z      = 3'b011;
    localparam logic [2:0] COND_NEVER  = 3'b100;
    localparam logic [2:0] COND_NC     = 3'b101;
    localparam logic [2:0] COND_NN     = 3'b110;
    localparam logic [2:0] COND_NZ     = 3'b111;

    localparam int CLS_MSB = 11;
    localparam int CLS_LSB = 9;
    localparam int DST_MSB = 8;
    localparam int DST_LSB = 6;

    typedef struct packed {
        logic reg_w_en;
        logic s_sel;
        logic adr_sel;
        logic pc_ld;
        logic pc_inc;
        logic ir_ld;
        logic mem_r_en;
        logic mem_w_en;
    } strobes_t;

    // BR is absent here: its pc_ld depends on the live flags and is added by the top.
    function automatic strobes_t state_strobes(input state_e s);
        strobes_t r;
        r = '0;
        case (s)
            ST_FETCH: begin r.mem_r_en = 1'b1; r.ir_ld = 1'b1; r.pc_inc = 1'b1; end
            ST_ALU:   begin r.reg_w_en = 1'b1; end
            ST_LDI:   begin r.mem_r_en = 1'b1; r.s_sel = 1'b1; r.reg_w_en = 1'b1; r.pc_inc = 1'b1; end
            ST_LD:    begin r.adr_sel = 1'b1; r.mem_r_en = 1'b1; r.s_sel = 1'b1; r.reg_w_en = 1'b1; end
            ST_ST:    begin r.adr_sel = 1'b1; r.mem_w_en = 1'b1; end
            ST_JMP:   begin r.pc_ld = 1'b1; end
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_cu_brcond.sv
// cpu_cu_brcond -- combinational branch condition evaluator.
//
// Ports:
//   cond   in  3  condition code from IR[8:6]
//   C,N,Z  in  1  flags from the execution unit
//   taken  out 1  condition holds
module cpu_cu_brcond
    import cpu_cu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       C,
    input  logic       N,
    input  logic       Z,
    output logic       taken
);

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        taken = 1'b0;
        case (cond)
            COND_ALWAYS: taken = 1'b1;
            COND_C:      taken = C;
            COND_N:      taken = N;
            COND_Z:      taken = Z;
            COND_NEVER:  taken = 1'b0;
            COND_NC:     taken = ~C;
            COND_NN:     taken = ~N;
            COND_NZ:     taken = ~Z;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_cu.sv
// cpu_cu -- Moore fetch/decode/execute control unit for the 16-bit CPU.
//
// Parameters:
//   HALT_ON_ILLEGAL  1: illegal class enters HALT; 0: executed as a NOP
//   WAIT_LIMIT       mem_rdy wait cycles before bus_err (0 = forever); CU_MEM_WAIT_EN only
//
// Ports:
//   clk, reset (async, active-high)
//   IR_Out[15:0], C, N, Z          in   instruction register and flags
//   mem_rdy                        in   memory ready (CU_MEM_WAIT_EN only)
//   reg_w_en, S_Sel, adr_sel,      out  execution-unit strobes
//   pc_ld, pc_inc, ir_ld
//   mem_r_en, mem_w_en             out  memory strobes
//   halted, illegal, bus_err       out  status (illegal/bus_err sticky until reset)
//
// Optional feature macro: CU_MEM_WAIT_EN (memory wait states with timeout).
module cpu_cu
    import cpu_cu_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
`ifdef CU_MEM_WAIT_EN
    ,
    parameter int WAIT_LIMIT = 0
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR_Out,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
`ifdef CU_MEM_WAIT_EN
    input  logic        mem_rdy,
`endif
    output logic        reg_w_en,
    output logic        S_Sel,
    output logic        adr_sel,
    output logic        pc_ld,
    output logic        pc_inc,
    output logic        ir_ld,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic        halted,
    output logic        illegal,
    output logic        bus_err
);

    state_e     state_q, state_d;
    strobes_t   str_q, str_d;
    logic       halted_q, halted_d;
    logic       illegal_q, illegal_d;
    logic [2:0] cls, cond;
    logic       br_taken;
    logic       rdy_gate;
    logic       unused_ir;

    assign cls       = IR_Out[CLS_MSB:CLS_LSB];
    assign cond      = IR_Out[DST_MSB:DST_LSB];
    assign unused_ir = ^{IR_Out[15:12], IR_Out[5:0]};

    cpu_cu_brcond u_brcond (
        .cond  (cond),
        .C     (C),
        .N     (N),
        .Z     (Z),
        .taken (br_taken)
    );

`ifdef CU_MEM_WAIT_EN
    localparam int            CW        = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

    logic          mem_phase;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          bus_err_q, bus_err_d;

    assign mem_phase = (state_q == ST_FETCH) || (state_q == ST_LDI) ||
                       (state_q == ST_LD)    || (state_q == ST_ST);
    // Write/increment strobes fire only in the cycle the memory completes.
    assign rdy_gate  = mem_rdy | ~mem_phase;
    assign bus_err   = bus_err_q;
`else
    assign rdy_gate  = 1'b1;
    assign bus_err   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_RST:    state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (cls)
                    CLS_ALU:  state_d = ST_ALU;
                    CLS_LDI:  state_d = ST_LDI;
                    CLS_LD:   state_d = ST_LD;
                    CLS_ST:   state_d = ST_ST;
                    CLS_JMP:  state_d = ST_JMP;
                    CLS_BR:   state_d = ST_BR;
                    CLS_HALT: state_d = ST_HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = HALT_ON_ILLEGAL ? ST_HALT : ST_FETCH;
                    end
                endcase
            end
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase

`ifdef CU_MEM_WAIT_EN
        wcnt_d    = '0;
        bus_err_d = bus_err_q;
        if (mem_phase && !mem_rdy) begin
            state_d = state_q;
            if (WAIT_LIMIT != 0 && wcnt_q == WAIT_LAST) begin
                bus_err_d = 1'b1;
                state_d   = ST_HALT;
            end else if (WAIT_LIMIT != 0) begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
`endif

        // Outputs are registered against the state being entered.
        str_d    = state_strobes(state_d);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RST;
            str_q     <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
`ifdef CU_MEM_WAIT_EN
            wcnt_q    <= '0;
            bus_err_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            str_q     <= str_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
`ifdef CU_MEM_WAIT_EN
            wcnt_q    <= wcnt_d;
            bus_err_q <= bus_err_d;
`endif
        end
    end

    assign reg_w_en = str_q.reg_w_en & rdy_gate;
    assign S_Sel    = str_q.s_sel;
    assign adr_sel  = str_q.adr_sel;
    assign pc_ld    = str_q.pc_ld | ((state_q == ST_BR) & br_taken);
    assign pc_inc   = str_q.pc_inc & rdy_gate;
    assign ir_ld    = str_q.ir_ld & rdy_gate;
    assign mem_r_en = str_q.mem_r_en;
    assign mem_w_en = str_q.mem_w_en;
    assign halted   = halted_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_cpu_cu.sv
// tb_cpu_cu -- self-checking bench for cpu_cu.
// Two instances share every input: u_halt (HALT_ON_ILLEGAL=1) and u_nop
// (HALT_ON_ILLEGAL=0). A per-instance instruction-phase model predicts the
// outputs of every cycle.
module tb_cpu_cu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] ir = '0;
    logic        c = 1'b0, n = 1'b0, z = 1'b0;
`ifdef CU_MEM_WAIT_EN
    logic        mem_rdy = 1'b1;
`endif

    // bit order: 10 reg_w_en, 9 S_Sel, 8 adr_sel, 7 pc_ld, 6 pc_inc, 5 ir_ld,
    //            4 mem_r_en, 3 mem_w_en, 2 halted, 1 illegal, 0 bus_err
    wire [10:0] o0, o1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpu_cu #(.HALT_ON_ILLEGAL(1'b1)
`ifdef CU_MEM_WAIT_EN
        , .WAIT_LIMIT(4)
`endif
    ) u_halt (
        .clk(clk), .reset(reset), .IR_Out(ir), .C(c), .N(n), .Z(z),
`ifdef CU_MEM_WAIT_EN
        .mem_rdy(mem_rdy),
`endif
        .reg_w_en(o0[10]), .S_Sel(o0[9]), .adr_sel(o0[8]), .pc_ld(o0[7]),
        .pc_inc(o0[6]), .ir_ld(o0[5]), .mem_r_en(o0[4]), .mem_w_en(o0[3]),
        .halted(o0[2]), .illegal(o0[1]), .bus_err(o0[0])
    );

    cpu_cu #(.HALT_ON_ILLEGAL(1'b0)
`ifdef CU_MEM_WAIT_EN
        , .WAIT_LIMIT(4)
`endif
    ) u_nop (
        .clk(clk), .reset(reset), .IR_Out(ir), .C(c), .N(n), .Z(z),
`ifdef CU_MEM_WAIT_EN
        .mem_rdy(mem_rdy),
`endif
        .reg_w_en(o1[10]), .S_Sel(o1[9]), .adr_sel(o1[8]), .pc_ld(o1[7]),
        .pc_inc(o1[6]), .ir_ld(o1[5]), .mem_r_en(o1[4]), .mem_w_en(o1[3]),
        .halted(o1[2]), .illegal(o1[1]), .bus_err(o1[0])
    );

    // phase: 0 idle after reset, 1 fetch, 2 decode, 3 execute
    typedef struct {
        int         phase;
        logic [2:0] cls;
        bit         halt;
        bit         ill;
    } mdl_t;

    mdl_t m [2];
    bit   hoi [2];
    logic [10:0] last_o0, last_o1;

    function automatic logic br_rule(input logic [2:0] cond, input logic cv, nv, zv);
        logic [3:0] f;
        logic       t;
        f = {zv, nv, cv, 1'b1};
        t = f[cond[1:0]];
        return cond[2] ? ~t : t;
    endfunction

    function automatic logic [10:0] expect_out(input mdl_t s, input logic [15:0] ir_v,
                                               input logic cv, nv, zv);
        logic rw, ss, as, pl, pi, il, mr, mw;
        {rw, ss, as, pl, pi, il, mr, mw} = '0;
        if (s.halt) return {8'b0, 1'b1, s.ill, 1'b0};
        if (s.phase == 1) begin
            mr = 1'b1; il = 1'b1; pi = 1'b1;
        end else if (s.phase == 3) begin
            case (s.cls)
                3'd0: rw = 1'b1;
                3'd1: begin mr = 1'b1; ss = 1'b1; rw = 1'b1; pi = 1'b1; end
                3'd2: begin as = 1'b1; mr = 1'b1; ss = 1'b1; rw = 1'b1; end
                3'd3: begin as = 1'b1; mw = 1'b1; end
                3'd4: pl = 1'b1;
                3'd5: pl = br_rule(ir_v[8:6], cv, nv, zv);
                default: ;
            endcase
        end
        return {rw, ss, as, pl, pi, il, mr, mw, 1'b0, s.ill, 1'b0};
    endfunction

    function automatic mdl_t advance(input mdl_t s, input logic [15:0] ir_v, input bit h);
        mdl_t r;
        r = s;
        if (s.halt) return r;
        case (s.phase)
            0: r.phase = 1;
            1: r.phase = 2;
            2: begin
                r.cls = ir_v[11:9];
                if (r.cls == 3'b110) begin
                    r.ill = 1'b1;
                    if (h) r.halt = 1'b1;
                    else   r.phase = 1;
                end else if (r.cls == 3'b111) begin
                    r.halt = 1'b1;
                end else begin
                    r.phase = 3;
                end
            end
            default: r.phase = 1;
        endcase
        return r;
    endfunction

    // One clock cycle: drive at the falling edge, compare both instances, step the model.
    task automatic cycle(input logic [15:0] ir_v, input logic cv, nv, zv, input string tag);
        logic [10:0] exp_v, act_v;
        @(negedge clk);
        ir = ir_v; c = cv; n = nv; z = zv;
        #1;
        last_o0 = o0;
        last_o1 = o1;
        for (int i = 0; i < 2; i++) begin
            exp_v = expect_out(m[i], ir_v, cv, nv, zv);
            act_v = (i == 0) ? o0 : o1;
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL %s inst%0d: got %b expected %b", tag, i, act_v, exp_v);
            end
            m[i] = advance(m[i], ir_v, hoi[i]);
        end
    endtask

    // Assert reset at once (outputs must drop immediately), release, then consume the RST cycle.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (o0 !== 11'b0 || o1 !== 11'b0) begin
            n_bad++;
            $display("FAIL %s_in_reset: got %b/%b expected all zero", tag, o0, o1);
        end
        for (int i = 0; i < 2; i++) begin
            m[i].phase = 0; m[i].halt = 1'b0; m[i].ill = 1'b0; m[i].cls = 3'b0;
        end
        @(posedge clk);
        #2 reset = 1'b0;
        cycle(16'h0000, 1'b0, 1'b0, 1'b0, {tag, "_rst_state"});
    endtask

    task automatic run_instr(input logic [15:0] ir_v, input logic cv, nv, zv, input string tag);
        cycle(ir_v, cv, nv, zv, {tag, "_fetch"});
        cycle(ir_v, cv, nv, zv, {tag, "_decode"});
        cycle(ir_v, cv, nv, zv, {tag, "_exec"});
    endtask

    task automatic test_reset();
        do_reset("reset");
        cycle(16'h0000, 1'b0, 1'b0, 1'b0, "reset_first_fetch");
    endtask

    task automatic test_alu();
        do_reset("alu");
        run_instr(16'hB040, 1'b0, 1'b0, 1'b0, "alu");
        cycle(16'hB040, 1'b0, 1'b0, 1'b0, "alu_next_fetch");
    endtask

    task automatic test_ldi();
        int incs;
        do_reset("ldi");
        incs = 0;
        cycle(16'h0240, 1'b0, 1'b0, 1'b0, "ldi_fetch");  incs += int'(last_o0[6]);
        cycle(16'h0240, 1'b0, 1'b0, 1'b0, "ldi_decode"); incs += int'(last_o0[6]);
        cycle(16'h0240, 1'b0, 1'b0, 1'b0, "ldi_exec");   incs += int'(last_o0[6]);
        n_cmp++;
        if (incs != 2) begin
            n_bad++;
            $display("FAIL ldi_pc_advance: got %0d increments expected 2", incs);
        end
    endtask

    task automatic test_branch();
        do_reset("br");
        run_instr(16'h0AC0, 1'b0, 1'b0, 1'b1, "br_z_taken");
        n_cmp++;
        if (last_o0[7] !== 1'b1) begin
            n_bad++;
            $display("FAIL br_z1_pc_ld: got %b expected 1", last_o0[7]);
        end
        run_instr(16'h0AC0, 1'b1, 1'b1, 1'b0, "br_z_not_taken");
        n_cmp++;
        if (last_o0[7] !== 1'b0) begin
            n_bad++;
            $display("FAIL br_z0_pc_ld: got %b expected 0", last_o0[7]);
        end
        for (int k = 0; k < 8; k++) begin
            logic [2:0] f;
            f = 3'(k);
            run_instr(16'h0B00, f[0], f[1], f[2], "br_never");
            n_cmp++;
            if (last_o0[7] !== 1'b0) begin
                n_bad++;
                $display("FAIL br_never_pc_ld flags=%b: got %b expected 0", f, last_o0[7]);
            end
        end
        for (int k = 0; k < 8; k++)
            run_instr({4'($urandom), 3'b101, 3'(k), 6'($urandom)},
                      1'($urandom), 1'($urandom), 1'($urandom), "br_cond");
        run_instr(16'h0800, 1'b0, 1'b0, 1'b0, "jmp");
    endtask

    task automatic test_reset_mid_st();
        do_reset("st");
        run_instr(16'h0600, 1'b0, 1'b0, 1'b0, "st");
        do_reset("st_mid");
        cycle(16'h0000, 1'b0, 1'b0, 1'b0, "st_after_reset_fetch");
    endtask

    task automatic test_illegal();
        do_reset("ill");
        cycle(16'h0C00, 1'b0, 1'b0, 1'b0, "ill_fetch");
        cycle(16'h0C00, 1'b0, 1'b0, 1'b0, "ill_decode");
        cycle(16'h0000, 1'b0, 1'b0, 1'b0, "ill_after");
        n_cmp++;
        if (last_o0[2:1] !== 2'b11 || last_o1[2:1] !== 2'b01 || last_o1[5] !== 1'b1) begin
            n_bad++;
            $display("FAIL ill_outcome: got halt_inst %b nop_inst %b expected halted+illegal / illegal+fetch",
                     last_o0, last_o1);
        end
        for (int k = 0; k < 4; k++)
            cycle(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "ill_hold");
    endtask

    task automatic test_random();
        do_reset("rnd");
        for (int k = 0; k < 400; k++) begin
            if ((m[0].halt && m[1].halt) || $urandom_range(0, 99) < 2)
                do_reset("rnd");
            cycle(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "rnd");
        end
    endtask

`ifdef CU_MEM_WAIT_EN
    task automatic test_mem_wait();
        int pulses;
        do_reset("wait");
        mem_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (o0[5] !== 1'b0 || o0[4] !== 1'b1 || o0[2] !== 1'b0) begin
                n_bad++;
                $display("FAIL wait_hold cycle %0d: got %b expected mem_r_en only", k, o0);
            end
        end
        @(negedge clk); #1;
        n_cmp++;
        if (o0[2] !== 1'b1 || o0[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_timeout: got halted=%b bus_err=%b expected 1/1", o0[2], o0[0]);
        end
        mem_rdy = 1'b1;
        do_reset("wait2");
        pulses = 0;
        mem_rdy = 1'b0;
        @(negedge clk); #1; pulses += int'(o0[5]);
        mem_rdy = 1'b1;
        @(negedge clk); #1; pulses += int'(o0[5]);
        @(negedge clk); #1; pulses += int'(o0[5]);
        n_cmp++;
        if (pulses != 1 || o0[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_single_ir_ld: got %0d pulses bus_err=%b expected 1/0", pulses, o0[0]);
        end
        do_reset("wait_end");
    endtask
`endif

    initial begin
        hoi[0] = 1'b1;
        hoi[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m[i].phase = 0; m[i].halt = 1'b0; m[i].ill = 1'b0; m[i].cls = 3'b0;
        end
        #2;
        test_reset();
        test_alu();
        test_ldi();
        test_branch();
        test_reset_mid_st();
        test_illegal();
`ifdef CU_MEM_WAIT_EN
        test_mem_wait();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_cu.md
Name: cpu_cu

Overview:
- Control unit for the 16-bit CPU execution unit. It is a Moore fetch/decode/execute state machine.
- It reads the instruction register and the C/N/Z flags back from the execution unit. It drives every execution-unit control strobe plus the memory read and write enables.
- Together with the execution unit it forms the complete CPU core.

Parameters:
- HALT_ON_ILLEGAL, 1, 1: an illegal class enters HALT. 0: an illegal class is executed as a NOP.
- WAIT_LIMIT, 0, maximum mem_rdy wait cycles before setting bus_err. 0 means wait forever. Used only with CU_MEM_WAIT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- IR_Out  in  16  instruction register contents.
- C  in  1  carry flag from the execution unit.
- N  in  1  negative flag from the execution unit.
- Z  in  1  zero flag from the execution unit.
- reg_w_en  out  1  register file write enable.
- S_Sel  out  1  1 selects D_in as the S operand.
- adr_sel  out  1  1 selects Reg_Out as the address; 0 selects PC.
- pc_ld  out  1  load PC from the ALU output.
- pc_inc  out  1  increment PC.
- ir_ld  out  1  load IR from D_in.
- mem_r_en  out  1  memory read strobe.
- mem_w_en  out  1  memory write strobe (D_out is the data).
- halted  out  1  core is stopped.
- illegal  out  1  sticky flag: an illegal class was decoded.
- bus_err  out  1  sticky flag: memory wait timeout (CU_MEM_WAIT_EN only; tied 0 otherwise).
- mem_rdy  in  1  memory ready (port exists only with CU_MEM_WAIT_EN).

Behaviour:
- Instruction fields:
  - IR[15:12] is the ALU op and is passed straight to the execution unit.
  - IR[11:9] is the class.
  - IR[8:6] is the destination register or the branch condition.
  - Classes: 000 ALU, 001 LDI, 010 LD, 011 ST, 100 JMP, 101 BR, 111 HALT. Class 110 is illegal.
- States: RST, FETCH, DECODE, ALU, LDI, LD, ST, JMP, BR, HALT.
- Reset (async) forces RST. All outputs are 0 in RST and halted=illegal=bus_err=0. The first clock after reset deasserts moves RST->FETCH.
- FETCH: adr_sel=0, mem_r_en=1, ir_ld=1, pc_inc=1. Next state is DECODE.
- DECODE: all strobes 0. Next state is chosen from IR_Out[11:9] as registered by FETCH.
- ALU: reg_w_en=1, S_Sel=0. Next state is FETCH.
- LDI: adr_sel=0, mem_r_en=1, S_Sel=1, reg_w_en=1, pc_inc=1. The immediate word at PC is written to R[IR[8:6]]. Next state is FETCH.
- LD: adr_sel=1, mem_r_en=1, S_Sel=1, reg_w_en=1. Next state is FETCH.
- ST: adr_sel=1, mem_w_en=1, reg_w_en=0. Next state is FETCH.
- JMP: pc_ld=1. Next state is FETCH.
- BR: pc_ld is asserted when the condition holds, using the flags as presented in the BR cycle.
  - Conditions on IR[8:6]: 000 always, 001 C, 010 N, 011 Z, 100 never, 101 !C, 110 !N, 111 !Z.
  - Next state is FETCH.
- HALT: halted=1, all strobes 0, and the state is held until reset.
- Illegal class:
  - illegal is set sticky.
  - With HALT_ON_ILLEGAL=1 the next state is HALT; otherwise it is FETCH.
- Cycle counts: ALU, LD, ST, JMP and BR take 3 cycles; LDI takes 3 cycles and consumes 2 words.
- All outputs are decoded from the registered state only (Moore); no output is a combinational function of IR_Out except BR's pc_ld.
- Invariants:
  - pc_ld and pc_inc are never 1 in the same cycle.
  - mem_r_en and mem_w_en are never 1 in the same cycle.
  - mem_w_en and reg_w_en are never 1 in the same cycle.
- Reset asserted mid-instruction drops all strobes immediately, including a half-done store.

Optional Feature:
- Macro: CU_MEM_WAIT_EN.
- Defined:
  - The mem_rdy port exists.
  - FETCH, LDI, LD and ST hold their state and all strobes until mem_rdy=1 is sampled. The write and increment strobes (ir_ld, pc_inc, reg_w_en) are gated to the mem_rdy cycle only.
  - A wait counter (width clog2(WAIT_LIMIT+1)) counts the cycles spent waiting. When it reaches WAIT_LIMIT (if nonzero), bus_err is set and the state goes to HALT.
- Undefined: memory is single-cycle, mem_rdy is absent and bus_err is tied 0.

Decomposition:
- Package cpu_cu_pkg holds:
  - the state enum;
  - the class codes (CLS_ALU ... CLS_HALT);
  - the branch condition codes;
  - the field position constants CLS_MSB=11, CLS_LSB=9, DST_MSB=8, DST_LSB=6.
- One sub-module, cpu_cu_brcond: a combinational branch condition evaluator with inputs cond[2:0], C, N, Z and output taken.

Test Plan:
- Reset mid-ST (assert reset while in ST) -> mem_w_en drops immediately; after release FETCH follows in 1 cycle.
- ALU instruction IR=16'hB040 (class 000) -> FETCH ir_ld=pc_inc=1, DECODE all strobes 0, ALU reg_w_en=1 with S_Sel=0, then back to FETCH; 3 cycles total.
- LDI (IR=16'h0240) -> the LDI cycle shows mem_r_en=S_Sel=reg_w_en=pc_inc=1 with adr_sel=0; PC advances by 2 over the instruction.
- BR cond 011 (Z) with Z=1 -> pc_ld=1; with Z=0 -> pc_ld=0. Cond 100 -> pc_ld never asserted.
- Class 110, HALT_ON_ILLEGAL=1 -> illegal=1, halted=1, strobes 0 thereafter until reset. With HALT_ON_ILLEGAL=0 -> illegal=1 and the next FETCH occurs.
- CU_MEM_WAIT_EN, WAIT_LIMIT=4, mem_rdy held 0 during FETCH -> no ir_ld for 4 cycles, then bus_err=1 and halted=1. A separate run with mem_rdy=1 on the 2nd cycle -> ir_ld pulses exactly once.
